// File: rtl/ifetch_unit.sv
// RV32 instruction fetch: owns the fetch PC, issues one word request at a time,
// buffers {pc, word} in a small FIFO for decode and squashes wrong-path state on redirect.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ifetch_unit: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t          fifo_q [FIFO_DEPTH];
    logic [1:0]      state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic            stale_q, stale_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            misalign_q;

    logic            fire_req;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic            fifo_nempty;
    logic            has_space;
    logic [31:0]     redirect_aligned;

    assign fifo_nempty      = (cnt_q != '0);
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    always_comb begin
        fire_req = (state_q == S_REQ) && imem_req_ready;
        rsp_take = (state_q == S_WAIT) && imem_rsp_valid;
        // A response racing a redirect, or answering a squashed request, never enters the FIFO.
        push     = rsp_take && !stale_q && !redirect_valid;
        pop      = fifo_nempty && instr_ready && !redirect_valid;

        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
        has_space = (cnt_d < DEPTH_C);

        // A squashed request completing its handshake must not advance the PC.
        fetch_pc_d = fetch_pc_q;
        if (fire_req && !stale_q)
            fetch_pc_d = req_addr_q + 32'd4;
        if (redirect_valid)
            fetch_pc_d = redirect_aligned;

        state_d    = state_q;
        req_addr_d = req_addr_q;
        stale_d    = stale_q;
        case (state_q)
            S_IDLE: begin
                if (has_space) begin
                    state_d    = S_REQ;
                    req_addr_d = fetch_pc_d;
                end
            end
            S_REQ: begin
                if (fire_req)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rsp_take) begin
                    stale_d = 1'b0;
                    if (has_space) begin
                        state_d    = S_REQ;
                        req_addr_d = fetch_pc_d;
                    end else begin
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Squash whatever is presented or in flight; an arriving response is already dropped above.
        if (redirect_valid && ((state_q == S_REQ) || (state_q == S_WAIT && !imem_rsp_valid)))
            stale_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            stale_q    <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            stale_q    <= stale_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    // Storage is not reset; outputs are masked by the occupancy count instead.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= '{pc: req_addr_q, data: imem_rsp_data};
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = req_addr_q;
    assign misalign_err   = misalign_q;
    assign instr_valid    = fifo_nempty;
    assign instr          = fifo_nempty ? fifo_q[rd_ptr_q].data : NOP;
    assign instr_pc       = fifo_nempty ? fifo_q[rd_ptr_q].pc   : RESET_PC;

endmodule
